// File: rtl/vga_update_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_update_scheduler_pkg
// Description : Scheduler state encoding and VGA timing constants shared with
//               the VGA controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_update_scheduler_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_TOTAL  = 525;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_update_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_update_scheduler_if
// Description : Processor write/commit, VGA line and pixel read signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_update_scheduler_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int Y_W    = 10
);
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              commit_req;
    logic [Y_W-1:0]    Y;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              wr_drop;

    modport master (
        output wr_strobe, wr_addr, wr_data, commit_req, Y, rd_addr,
        input  rd_data, busy, done, wr_drop
    );

    modport slave (
        input  wr_strobe, wr_addr, wr_data, commit_req, Y, rd_addr,
        output rd_data, busy, done, wr_drop
    );
endinterface
`default_nettype wire

// File: rtl/vga_update_scheduler_regfile.sv
`default_nettype none
// ============================================================================
// Module      : vga_update_scheduler_regfile
// Description : Staging + live register banks with write, copy and async read.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_update_scheduler_regfile #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              wr_en_i,
    input  wire logic [ADDR_W-1:0] wr_addr_i,
    input  wire logic [DATA_W-1:0] wr_data_i,
    input  wire logic              cp_en_i,
    input  wire logic [ADDR_W-1:0] cp_idx_i,
    input  wire logic [ADDR_W-1:0] rd_addr_i,
    output logic      [DATA_W-1:0] rd_data_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] stage_q [DEPTH];
    logic [DATA_W-1:0] live_q  [DEPTH];

    // Both banks clear on reset so an interrupted copy never leaves a mixed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
                live_q[i]  <= '0;
            end
        end else begin
            if (wr_en_i) stage_q[wr_addr_i] <= wr_data_i;
            if (cp_en_i) live_q[cp_idx_i]   <= stage_q[cp_idx_i];
        end
    end

    assign rd_data_o = live_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/vga_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vga_update_scheduler
// Description : Defers a staging->live bank commit to the next vertical-blank
//               rising edge, then copies one word per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_update_scheduler
    import vga_update_scheduler_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int Y_W      = 10,
    parameter int V_ACTIVE = VGA_V_ACTIVE
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    vga_update_scheduler_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    sched_state_e      state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              blank_dly_q;
    logic              busy_q;
    logic              done_q;
    logic              wr_drop_q;

    logic              blank_w;
    logic              blank_rise_w;
    logic              stage_we_w;
    logic              copy_en_w;
    logic              req_any_w;

    assign blank_w      = (bus.Y >= Y_W'(V_ACTIVE));
    assign blank_rise_w = blank_w & ~blank_dly_q;
    assign stage_we_w   = bus.wr_strobe & (state_q == ST_IDLE);
    assign copy_en_w    = (state_q == ST_COPY);
    assign req_any_w    = bus.wr_strobe | bus.commit_req;

    // blank_dly resets high so releasing reset inside blanking is not a rise.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            blank_dly_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_drop_q   <= 1'b0;
        end else begin
            blank_dly_q <= blank_w;
            done_q      <= 1'b0;
            wr_drop_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.commit_req) begin
                        state_q <= ST_ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    wr_drop_q <= req_any_w;
                    if (blank_rise_w) begin
                        state_q <= ST_COPY;
                        idx_q   <= '0;
                    end
                end
                ST_COPY: begin
                    wr_drop_q <= req_any_w;
                    idx_q     <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    vga_update_scheduler_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (CLK),
        .rst_n     (RESET),
        .wr_en_i   (stage_we_w),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .cp_en_i   (copy_en_w),
        .cp_idx_i  (idx_q),
        .rd_addr_i (bus.rd_addr),
        .rd_data_o (bus.rd_data)
    );

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_drop = wr_drop_q;

endmodule
`default_nettype wire

// File: doc/vga_update_scheduler.md
Name: vga_update_scheduler

Overview:
- Schedules PicoBlaze-originated display updates (RTC digits, cursor, format flags) into the register bank read by the VGA pixel generator.
- The processor writes into a staging bank, then requests a commit.
- The block defers the commit to the start of vertical blanking and copies staging to live one word per clock, so a visible frame never shows a partial update.
- Sits between the PicoBlaze output-port decode and the VGA controller's pixel/graphics logic.

Parameters:
- ADDR_W, 4, address width; bank depth = 2**ADDR_W words (16).
- DATA_W, 8, word width.
- Y_W, 10, width of the VGA line counter input.
- V_ACTIVE, 480, first non-visible line; blanking when Y >= V_ACTIVE.

Ports:
- CLK  in  1  system clock (50 MHz), all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- wr_strobe  in  1  one-cycle write pulse from the processor port decode.
- wr_addr  in  ADDR_W  staging bank address.
- wr_data  in  DATA_W  staging bank data.
- commit_req  in  1  one-cycle pulse: publish staging bank at the next blanking.
- Y  in  Y_W  current VGA line from the VGA controller.
- rd_addr  in  ADDR_W  pixel-side read address.
- rd_data  out  DATA_W  live bank word at rd_addr, combinational.
- busy  out  1  high in ARMED and COPY.
- done  out  1  one-cycle pulse when a commit completes.
- wr_drop  out  1  one-cycle pulse when a write or commit request is rejected.

Behaviour:
- Reset (RESET=0, async): state=IDLE; all staging and live words=0; copy index=0; blank_d=1 (so a reset released mid-blank does not count as a blank rise); busy=0, done=0, wr_drop=0.
- blank = (Y >= V_ACTIVE). blank_rise = blank & ~blank_d, where blank_d is blank registered every cycle.
- IDLE:
  - wr_strobe writes staging[wr_addr] <= wr_data on that edge.
  - commit_req -> ARMED next cycle.
  - wr_strobe and commit_req in the same cycle: the write lands, then ARMED.
- ARMED:
  - busy=1.
  - Waits for blank_rise -> COPY with idx=0.
  - If commit_req arrives while already in blanking, it still waits for the next blank rise (whole-frame deferral, deterministic).
- COPY:
  - busy=1.
  - Each cycle live[idx] <= staging[idx], then idx++.
  - idx wraps at 2**ADDR_W-1 -> IDLE, with done=1 on the cycle after the last word is written (that is, the first IDLE cycle).
  - The copy takes exactly 2**ADDR_W cycles.
- Rejections (ARMED or COPY):
  - wr_strobe does not modify staging; wr_drop=1 for one cycle.
  - commit_req is ignored; wr_drop=1.
  - Both in the same cycle give a single wr_drop pulse.
- rd_data always reflects the live bank. A read of the word being copied returns the old value in that cycle and the new value from the next cycle.
- Reset mid-COPY: live bank ends up fully cleared (never half old/half new), state IDLE.
- Y discontinuity (VGA reset) while ARMED: the block keeps waiting; there is no timeout.
- Widths: idx is ADDR_W bits with natural wrap. Y is compared unsigned.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, ARMED=2'd1, COPY=2'd2), V_ACTIVE/V_TOTAL/H_ACTIVE VGA constants shared with the VGA controller.
- One natural sub-module: dual_bank_regfile (staging + live arrays, write port, copy port, async read port). The FSM and blank-edge detector live in the top.

Test Plan:
- Reset then idle: read all 16 addresses -> rd_data=0x00; busy=0, done=0, wr_drop=0.
- Deferred commit:
  - Stimulus: write 0x12 @3 and 0xA5 @15 in IDLE; commit_req with Y=100; step Y to 479.
  - Before blank: rd_data @3 stays 0x00 and busy=1.
  - At Y=480: the copy runs 16 cycles, done pulses exactly 17 cycles after the blank-rise cycle, then rd_data@3=0x12 and @15=0xA5.
- Rejection: during ARMED, write 0xFF @3 plus a second commit_req -> wr_drop pulses; after commit, rd_data@3=0x12, and only one done occurs.
- Commit issued in blanking: commit_req at Y=500 -> no copy until Y wraps to 0, passes 479, and reaches 480 again.
- Simultaneous: wr_strobe(@7, 0x3C) and commit_req in the same IDLE cycle -> after the commit, rd_data@7=0x3C.
- Reset mid-COPY: assert RESET=0 at copy idx=8 -> all outputs 0 immediately; after release, every rd_data=0x00 and state IDLE.
